// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Front-end for a 4-bit combinational ALU. Instruction words are queued in a
// small command FIFO, issued one at a time to the ALU from registers, and the
// captured result is returned with its sequence tag and flags.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   cmd_valid      command word present
//   cmd_ready      FIFO can accept (registered, equals !full)
//   cmd_data[10:0] {opcode[10:8], operand_a[7:4], operand_b[3:0]}
//   alu_opcode     registered opcode to the ALU
//   alu_operand_a  registered operand A to the ALU
//   alu_operand_b  registered operand B to the ALU
//   alu_result     combinational result from the ALU
//   rsp_valid      response present
//   rsp_ready      consumer accepts the response
//   rsp_result     captured result (0 on divide-by-zero)
//   rsp_tag        tag of the originating command
//   rsp_zero       rsp_result == 0
//   rsp_div0       command was a divide with operand_b == 0
//   fifo_count     current FIFO occupancy (registered)
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [10:0]                   cmd_data,
  output logic [2:0]                    alu_opcode,
  output logic [3:0]                    alu_operand_a,
  output logic [3:0]                    alu_operand_b,
  input  logic [3:0]                    alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [3:0]                    rsp_result,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic                          rsp_zero,
  output logic                          rsp_div0,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 11 + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;

  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [2:0]         alu_opcode_q, alu_opcode_d;
  logic [3:0]         alu_a_q, alu_a_d;
  logic [3:0]         alu_b_q, alu_b_d;
  logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
  logic               pend_div0_q, pend_div0_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [3:0]         rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_div0_q, rsp_div0_d;

  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   head;
  logic [10:0]        head_cmd;
  logic [TAG_W-1:0]   head_tag;
  logic [3:0]         issue_result;

  // FIFO bookkeeping: handshakes, pointers, occupancy and tag counter
  always_comb begin
    push     = cmd_valid && cmd_ready_q;
    // Pops are only taken from IDLE, so at most one command is in flight
    pop      = (state_q == S_IDLE) && (count_q != CNT_W'(0));
    head     = mem_q[rd_ptr_q];
    head_cmd = head[ENT_W-1:TAG_W];
    head_tag = head[TAG_W-1:0];

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
    tag_d    = push ? (tag_q + TAG_W'(1'b1))    : tag_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase

    // Registered ready tracks the post-edge occupancy; no write-through when full
    cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // FIFO storage; entries need no reset because occupancy guards every read
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= {cmd_data, tag_q};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: ALU issue registers and response capture
  always_comb begin
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    pend_tag_d   = pend_tag_q;
    pend_div0_d  = pend_div0_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_div0_d   = rsp_div0_q;
    // Divide-by-zero still goes to the ALU, but its output is discarded
    issue_result = pend_div0_q ? 4'b0000 : alu_result;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          alu_opcode_d = head_cmd[10:8];
          alu_a_d      = head_cmd[7:4];
          alu_b_d      = head_cmd[3:0];
          pend_tag_d   = head_tag;
          pend_div0_d  = (head_cmd[10:8] == 3'b010) && (head_cmd[3:0] == 4'b0000);
        end else begin
          pend_div0_d  = pend_div0_q;
        end
      end
      S_ISSUE: begin
        rsp_result_d = issue_result;
        rsp_zero_d   = (issue_result == 4'b0000);
        rsp_div0_d   = pend_div0_q;
        rsp_tag_d    = pend_tag_q;
        rsp_valid_d  = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: rsp_valid_d = 1'b0;
    endcase
  end

  // Datapath and FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= PTR_W'(1'b0);
      rd_ptr_q     <= PTR_W'(1'b0);
      count_q      <= CNT_W'(1'b0);
      cmd_ready_q  <= 1'b1;
      tag_q        <= TAG_W'(1'b0);
      alu_opcode_q <= 3'b000;
      alu_a_q      <= 4'b0000;
      alu_b_q      <= 4'b0000;
      pend_tag_q   <= TAG_W'(1'b0);
      pend_div0_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 4'b0000;
      rsp_tag_q    <= TAG_W'(1'b0);
      rsp_zero_q   <= 1'b0;
      rsp_div0_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_ready_q  <= cmd_ready_d;
      tag_q        <= tag_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      pend_tag_q   <= pend_tag_d;
      pend_div0_q  <= pend_div0_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_div0_q   <= rsp_div0_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign fifo_count    = count_q;
  assign alu_opcode    = alu_opcode_q;
  assign alu_operand_a = alu_a_q;
  assign alu_operand_b = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_div0      = rsp_div0_q;

endmodule
